// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: request/grant memory port with multiple outstanding requests,
// an in-order prefetch FIFO feeding the decode register, and redirect-driven flush.
module fetch_prefetch_unit #(
  parameter int unsigned          XLEN            = 32,
  parameter logic [XLEN-1:0]      RESET_PC        = '0,
  parameter int unsigned          FIFO_DEPTH      = 4,
  parameter int unsigned          MAX_OUTSTANDING = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          redirect_i,
  input  logic [XLEN-1:0]               redirect_pc_i,
  input  logic                          stall_d_i,
  output logic                          imem_req_o,
  output logic [XLEN-1:0]               imem_addr_o,
  input  logic                          imem_gnt_i,
  input  logic                          imem_rvalid_i,
  input  logic [31:0]                   imem_rdata_i,
  output logic [31:0]                   instr_d_o,
  output logic [XLEN-1:0]               pc_d_o,
  output logic [XLEN-1:0]               pc_plus4_d_o,
  output logic                          valid_d_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic [OW-1:0]   discard_q, discard_d;

  logic [XLEN-1:0] tag_q [MAX_OUTSTANDING];
  logic [TW-1:0]   tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

  logic [31:0]     fifo_instr_q [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_pc_q    [FIFO_DEPTH];
  logic [AW:0]     fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  logic [AW:0]     fifo_cnt;
  logic [CW:0]     occupancy;

  logic gnt_acc, rsp_acc, rsp_keep, fifo_pop;
  logic [XLEN-1:0] tag_head;

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    if (p == TW'(MAX_OUTSTANDING - 1)) return '0;
    return p + TW'(1);
  endfunction

  // Credit: queued plus in-flight instructions never exceed FIFO capacity.
  always_comb begin
    fifo_cnt   = fifo_wr_q - fifo_rd_q;
    occupancy  = {1'b0, fifo_cnt} + (CW + 1)'(outst_q);
    imem_req_o = rst_n & ~redirect_i & (outst_q < OW'(MAX_OUTSTANDING)) &
                 (occupancy < (CW + 1)'(FIFO_DEPTH));
    imem_addr_o  = fetch_pc_q;
    fifo_count_o = fifo_cnt;
    gnt_acc  = imem_req_o & imem_gnt_i;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_acc  = imem_rvalid_i & (outst_q != '0);
    rsp_keep = rsp_acc & ~redirect_i & (discard_q == '0);
    fifo_pop = ~redirect_i & ~stall_d_i & (fifo_cnt != '0);
    tag_head = tag_q[tag_rd_q];
  end

  always_comb begin
    outst_d  = outst_q + OW'(gnt_acc) - OW'(rsp_acc);
    tag_rd_d = rsp_acc ? tag_inc(tag_rd_q) : tag_rd_q;
    tag_wr_d = gnt_acc ? tag_inc(tag_wr_q) : tag_wr_q;
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
      discard_d  = outst_q - OW'(rsp_acc);
      fifo_rd_d  = '0;
      fifo_wr_d  = '0;
    end else begin
      fetch_pc_d = gnt_acc ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
      discard_d  = (rsp_acc && discard_q != '0) ? discard_q - OW'(1) : discard_q;
      fifo_rd_d  = fifo_rd_q + (AW + 1)'(fifo_pop);
      fifo_wr_d  = fifo_wr_q + (AW + 1)'(rsp_keep);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
      fifo_rd_q  <= '0;
      fifo_wr_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_wr_q  <= fifo_wr_d;
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (gnt_acc) tag_q[tag_wr_q] <= fetch_pc_q;
    if (rsp_keep) begin
      fifo_instr_q[fifo_wr_q[AW-1:0]] <= imem_rdata_i;
      fifo_pc_q[fifo_wr_q[AW-1:0]]    <= tag_head;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_d_o    <= 1'b0;
      instr_d_o    <= '0;
      pc_d_o       <= '0;
      pc_plus4_d_o <= '0;
    end else if (redirect_i) begin
      valid_d_o <= 1'b0;
      instr_d_o <= '0;
    end else if (!stall_d_i) begin
      if (fifo_pop) begin
        valid_d_o    <= 1'b1;
        instr_d_o    <= fifo_instr_q[fifo_rd_q[AW-1:0]];
        pc_d_o       <= fifo_pc_q[fifo_rd_q[AW-1:0]];
        pc_plus4_d_o <= fifo_pc_q[fifo_rd_q[AW-1:0]] + XLEN'(4);
      end else begin
        valid_d_o <= 1'b0;
        instr_d_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomized bench for fetch_prefetch_unit: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fetch_prefetch_unit;

  localparam int unsigned XLEN  = 16;
  localparam logic [15:0] RPC   = 16'h0100;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;

  logic        clk, rst_n;
  logic        redirect_i, stall_d_i, imem_gnt_i, imem_rvalid_i;
  logic [15:0] redirect_pc_i;
  logic [31:0] imem_rdata_i;
  logic        imem_req_o, valid_d_o;
  logic [15:0] imem_addr_o, pc_d_o, pc_plus4_d_o;
  logic [31:0] instr_d_o;
  logic [2:0]  fifo_count_o;

  fetch_prefetch_unit #(
    .XLEN(XLEN), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .stall_d_i(stall_d_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_d_o(instr_d_o), .pc_d_o(pc_d_o), .pc_plus4_d_o(pc_plus4_d_o),
    .valid_d_o(valid_d_o), .fifo_count_o(fifo_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // ---------------- reference model ----------------
  typedef struct packed { logic [31:0] instr; logic [15:0] pc; } ent_t;
  ent_t        m_fifo[$];
  logic [15:0] m_tags[$];
  int          m_discard;
  logic [15:0] m_fpc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [15:0] m_pc, m_pc4;

  function automatic bit m_req();
    return rst_n && !redirect_i && (m_tags.size() < MAXO) &&
           (m_fifo.size() + m_tags.size() < DEPTH);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_upd
    ent_t        e;
    bit          grant, rsp;
    logic [15:0] tag;
    int          old_out;
    if (!rst_n) begin
      m_fifo.delete();
      m_tags.delete();
      m_discard = 0;
      m_fpc     = RPC;
      m_valid   = 1'b0;
      m_instr   = '0;
      m_pc      = '0;
      m_pc4     = '0;
    end else begin
      grant   = m_req() && imem_gnt_i;
      old_out = m_tags.size();
      rsp     = imem_rvalid_i && (old_out > 0);
      tag     = '0;
      if (rsp) tag = m_tags.pop_front();
      if (grant) m_tags.push_back(m_fpc);
      if (redirect_i) begin
        m_discard = old_out - (rsp ? 1 : 0);
        m_fifo.delete();
        m_valid = 1'b0;
        m_instr = '0;
        m_fpc   = {redirect_pc_i[15:2], 2'b00};
      end else begin
        if (!stall_d_i) begin
          if (m_fifo.size() > 0) begin
            e       = m_fifo.pop_front();
            m_valid = 1'b1;
            m_instr = e.instr;
            m_pc    = e.pc;
            m_pc4   = e.pc + 16'd4;
          end else begin
            m_valid = 1'b0;
            m_instr = '0;
          end
        end
        if (rsp) begin
          if (m_discard > 0) m_discard--;
          else begin
            e.instr = imem_rdata_i;
            e.pc    = tag;
            m_fifo.push_back(e);
          end
        end
        if (grant) m_fpc = m_fpc + 16'd4;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic check_model();
    chk("req",      32'(imem_req_o),   32'(m_req()));
    chk("addr",     32'(imem_addr_o),  32'(m_fpc));
    chk("valid",    32'(valid_d_o),    32'(m_valid));
    chk("instr",    instr_d_o,         m_instr);
    chk("pc",       32'(pc_d_o),       32'(m_pc));
    chk("pc_plus4", 32'(pc_plus4_d_o), 32'(m_pc4));
    chk("count",    32'(fifo_count_o), 32'(m_fifo.size()));
  endtask

  // ---------------- memory responder ----------------
  logic [15:0] mem_q[$];
  int          rsp_pct;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {~a, a} ^ 32'h5a5a_0000;
  endfunction

  // One cycle: model check before the edge, then respond in order after it.
  task automatic step();
    bit          g;
    logic [15:0] a;
    @(negedge clk);
    check_model();
    g = imem_req_o && imem_gnt_i;
    a = imem_addr_o;
    @(posedge clk);
    #1;
    if (g && rst_n) mem_q.push_back(a);
    if (mem_q.size() > 0 && $urandom_range(99) < rsp_pct) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(mem_q.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] a0, pc0;
    bit          found;

    rst_n = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; stall_d_i = 1'b0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0; rsp_pct = 100;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_d_o), 0);
    chk("rst_instr", instr_d_o, 0);
    chk("rst_pc",    32'(pc_d_o), 0);
    chk("rst_pc4",   32'(pc_plus4_d_o), 0);
    chk("rst_req",   32'(imem_req_o), 0);
    chk("rst_count", 32'(fifo_count_o), 0);

    // Release: gnt tied high, 1-cycle responses.
    rst_n = 1'b1; imem_gnt_i = 1'b1;
    #1;
    chk("first_req",  32'(imem_req_o), 1);
    chk("first_addr", 32'(imem_addr_o), 32'h100);
    step();
    chk("second_addr", 32'(imem_addr_o), 32'h104);
    chk("e1_valid",    32'(valid_d_o), 0);
    step();
    chk("e2_valid", 32'(valid_d_o), 0);
    step();
    chk("e3_valid", 32'(valid_d_o), 1);
    chk("e3_pc",    32'(pc_d_o), 32'h100);
    chk("e3_pc4",   32'(pc_plus4_d_o), 32'h104);
    chk("e3_instr", instr_d_o, mem_word(16'h100));
    step();
    chk("e4_pc", 32'(pc_d_o), 32'h104);
    repeat (16) step();

    // Grant held low: request persists at a fixed address and the FIFO drains.
    imem_gnt_i = 1'b0;
    #1;
    a0 = imem_addr_o;
    repeat (12) step();
    chk("gnt0_req",   32'(imem_req_o), 1);
    chk("gnt0_addr",  32'(imem_addr_o), 32'(a0));
    chk("gnt0_valid", 32'(valid_d_o), 0);
    chk("gnt0_instr", instr_d_o, 0);
    chk("gnt0_count", 32'(fifo_count_o), 0);

    // Decode stall: FIFO fills to capacity, requests stop, outputs freeze.
    imem_gnt_i = 1'b1; stall_d_i = 1'b1;
    pc0 = pc_d_o;
    repeat (6) step();
    chk("stall_count", 32'(fifo_count_o), 4);
    chk("stall_req",   32'(imem_req_o), 0);
    chk("stall_pc",    32'(pc_d_o), 32'(pc0));
    stall_d_i = 1'b0;
    repeat (10) step();

    // Redirect with two requests in flight.
    rsp_pct = 0;
    repeat (3) step();
    redirect_i = 1'b1; redirect_pc_i = 16'h2003; stall_d_i = 1'b1;
    #1;
    chk("redir_req", 32'(imem_req_o), 0);
    step();
    redirect_i = 1'b0;
    chk("redir_addr",  32'(imem_addr_o), 32'h2000);
    chk("redir_valid", 32'(valid_d_o), 0);
    chk("redir_count", 32'(fifo_count_o), 0);
    stall_d_i = 1'b0; rsp_pct = 100;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (valid_d_o) found = 1'b1;
    end
    chk("redir_found", 32'(found), 1);
    chk("redir_pc",    32'(pc_d_o), 32'h2000);

    // Address wrap at the top of a 16-bit space.
    redirect_i = 1'b1; redirect_pc_i = 16'hFFF9;
    step();
    redirect_i = 1'b0;
    chk("wrap_addr", 32'(imem_addr_o), 32'hFFF8);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (valid_d_o && pc_d_o == 16'hFFFC) found = 1'b1;
    end
    chk("wrap_found", 32'(found), 1);
    chk("wrap_pc4",   32'(pc_plus4_d_o), 32'h0000);

    // Randomized traffic, including back-to-back redirects.
    for (int blk = 0; blk < 10; blk++) begin
      rsp_pct = (blk % 3 == 0) ? 30 : ((blk % 3 == 1) ? 70 : 100);
      for (int i = 0; i < 200; i++) begin
        imem_gnt_i    = ($urandom_range(3) != 0);
        stall_d_i     = ($urandom_range(3) == 0);
        redirect_i    = ($urandom_range(19) == 0);
        redirect_pc_i = ($urandom_range(7) == 0) ? (16'hFFF0 | 16'($urandom_range(15)))
                                                 : 16'($urandom);
        step();
      end
    end

    // Reset mid-stream with two outstanding; a stray response afterwards is ignored.
    redirect_i = 1'b0; stall_d_i = 1'b0; imem_gnt_i = 1'b1; rsp_pct = 0;
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req",   32'(imem_req_o), 0);
    chk("arst_valid", 32'(valid_d_o), 0);
    chk("arst_instr", instr_d_o, 0);
    chk("arst_pc",    32'(pc_d_o), 0);
    chk("arst_pc4",   32'(pc_plus4_d_o), 0);
    chk("arst_count", 32'(fifo_count_o), 0);
    mem_q.delete();
    imem_rvalid_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1; rsp_pct = 100;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hdead_beef;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (valid_d_o) found = 1'b1;
    end
    chk("restart_found", 32'(found), 1);
    chk("restart_pc",    32'(pc_d_o), 32'h100);
    chk("restart_instr", instr_d_o, mem_word(16'h100));
    repeat (10) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
